// File: rtl/jt9346_eeprom.sv
// jt9346_eeprom: 93C46-style Microwire serial EEPROM, 64 x 16 by default.
// The host bit-bangs sclk/sdi/scs; everything is sampled in the clk domain.
// Words are stored complemented so that the all-zero power-up contents of
// the RAM read back as the erased value 16'hFFFF without any load step.
module jt9346_eeprom #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic sdi,
    output logic sdo,
    input  logic scs
);

    localparam int CW = $clog2(DW);
    localparam int NW = 1 << AW;

    typedef enum logic [2:0] {IDLE, CMD, READ, WDATA, BUSY, DONE} state_t;

    state_t          state_q;
    logic            sclk_q;
    logic [CW-1:0]   cnt_q;
    logic [AW:0]     cmd_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic            flag_q;
    logic            bulk_q;
    logic            sdo_q;
    logic [DW-1:0]   memInv_q [NW];

    logic            rise;
    logic [AW+1:0]   cmdFull;
    logic [1:0]      op;
    logic [AW-1:0]   cmdAddr;
    logic [DW-1:0]   dataFull;
    logic [DW-1:0]   rdWord;
    logic            cmdLast;
    logic            dataLast;
    logic            memWe;
    logic [AW-1:0]   memWaddr;
    logic [DW-1:0]   memWdata;

    assign rise     = sclk & ~sclk_q;
    assign cmdFull  = {cmd_q, sdi};
    assign op       = cmdFull[AW+1:AW];
    assign cmdAddr  = cmdFull[AW-1:0];
    assign dataFull = {data_q[DW-2:0], sdi};
    assign rdWord   = ~memInv_q[addr_q];
    assign cmdLast  = (state_q == CMD)   && rise && (cnt_q == CW'(AW + 1));
    assign dataLast = (state_q == WDATA) && rise && (cnt_q == CW'(DW - 1));
    assign sdo      = sdo_q;

    // Memory write port: single ERASE/WRITE commits and the bulk sweep in BUSY
    always_comb begin
        memWe    = 1'b0;
        memWaddr = addr_q;
        memWdata = data_q;
        if (!rst) begin
            if (state_q == BUSY && bulk_q) begin
                memWe = flag_q;
            end else if (scs && cmdLast && op == 2'b11) begin
                memWe    = flag_q;
                memWaddr = cmdAddr;
                memWdata = '1;
            end else if (scs && dataLast && !bulk_q) begin
                memWe    = flag_q;
                memWdata = dataFull;
            end
        end
    end

    // Word storage, held complemented; untouched by rst
    always_ff @(posedge clk) begin
        if (memWe) begin
            memInv_q[memWaddr] <= ~memWdata;
        end
    end

    // Protocol state machine with registered sdo
    always_ff @(posedge clk) begin
        sclk_q <= sclk;
        if (rst) begin
            state_q <= IDLE;
            sdo_q   <= 1'b1;
            flag_q  <= 1'b1;
            cnt_q   <= '0;
            bulk_q  <= 1'b0;
        end else if (!scs && !(state_q == BUSY && bulk_q)) begin
            state_q <= IDLE;
            sdo_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    sdo_q <= 1'b1;
                    cnt_q <= '0;
                    if (rise && sdi) begin
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    if (rise) begin
                        cmd_q <= cmdFull[AW:0];
                        cnt_q <= cnt_q + 1'b1;
                        if (cmdLast) begin
                            cnt_q  <= '0;
                            addr_q <= cmdAddr;
                            bulk_q <= 1'b0;
                            case (op)
                                2'b10: begin
                                    state_q <= READ;
                                    sdo_q   <= 1'b0;
                                end
                                2'b01: state_q <= WDATA;
                                2'b11: begin
                                    state_q <= BUSY;
                                    sdo_q   <= 1'b0;
                                end
                                default: begin
                                    case (cmdAddr[AW-1 -: 2])
                                        2'b11: begin
                                            flag_q  <= 1'b1;
                                            state_q <= DONE;
                                            sdo_q   <= 1'b1;
                                        end
                                        2'b00: begin
                                            flag_q  <= 1'b0;
                                            state_q <= DONE;
                                            sdo_q   <= 1'b1;
                                        end
                                        2'b10: begin
                                            state_q <= BUSY;
                                            bulk_q  <= 1'b1;
                                            addr_q  <= '0;
                                            data_q  <= '1;
                                            sdo_q   <= 1'b0;
                                        end
                                        default: begin
                                            state_q <= WDATA;
                                            bulk_q  <= 1'b1;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                READ: begin
                    if (rise) begin
                        sdo_q <= rdWord[CW'(DW - 1) - cnt_q];
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DW - 1)) begin
                            cnt_q  <= '0;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (rise) begin
                        data_q <= dataFull;
                        cnt_q  <= cnt_q + 1'b1;
                        if (dataLast) begin
                            cnt_q <= '0;
                            if (flag_q) begin
                                state_q <= BUSY;
                                sdo_q   <= 1'b0;
                                if (bulk_q) begin
                                    addr_q <= '0;
                                end
                            end else begin
                                state_q <= DONE;
                                sdo_q   <= 1'b1;
                            end
                        end
                    end
                end
                BUSY: begin
                    sdo_q <= 1'b0;
                    if (!bulk_q) begin
                        state_q <= DONE;
                        sdo_q   <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        if (addr_q == '1) begin
                            state_q <= DONE;
                            sdo_q   <= 1'b1;
                            bulk_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    sdo_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt9346_eeprom.sv
// tb_jt9346_eeprom: bit-bangs Microwire commands into the EEPROM, keeps a
// behavioural word model, and checks read streams through a scoreboard queue.
module tb_jt9346_eeprom;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic sdi = 1'b0;
    logic scs = 1'b0;
    logic sdo;

    int testsRun = 0;
    int testsFailed = 0;

    logic        lastSdo = 1'b1;
    int          lowRun = 0;
    int          lastLow = 0;
    logic [15:0] model [64];
    logic        modelFlag = 1'b1;
    logic [15:0] expQ [$];

    jt9346_eeprom dut (
        .clk (clk),
        .rst (rst),
        .sclk(sclk),
        .sdi (sdi),
        .sdo (sdo),
        .scs (scs)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Measure the length of each low pulse on sdo (busy indication)
    always @(negedge clk) begin
        if (sdo === 1'b0) begin
            lowRun = lowRun + 1;
        end else begin
            if (lowRun != 0) lastLow = lowRun;
            lowRun = 0;
        end
    end

    // Guard against a stuck bench
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One serial bit: setup, sclk rise, then sample sdo before sclk falls
    task automatic applyStimulus(input logic b);
        @(negedge clk);
        sdi  = b;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        lastSdo = sdo;
        sclk = 1'b0;
    endtask

    task automatic beginOp();
        @(negedge clk);
        scs  = 1'b1;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic endOp();
        @(negedge clk);
        scs  = 1'b0;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [5:0] a);
        applyStimulus(1'b1);
        for (int i = 1; i >= 0; i--) applyStimulus(op[i]);
        for (int i = 5; i >= 0; i--) applyStimulus(a[i]);
    endtask

    task automatic waitReady(input string tag, input int expLow);
        int n = 0;
        while (lastLow == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, lastLow, expLow);
        checkOutput({tag, " ready"}, {31'd0, sdo}, 32'd1);
    endtask

    task automatic readWords(input logic [5:0] a, input int n);
        logic [15:0] word;
        logic [5:0]  ma;
        ma = a;
        for (int i = 0; i < n; i++) begin
            expQ.push_back(model[ma]);
            ma = ma + 6'd1;
        end
        beginOp();
        sendCmd(2'b10, a);
        checkOutput("read dummy", {31'd0, lastSdo}, 32'd0);
        for (int i = 0; i < n; i++) begin
            word = '0;
            for (int b = 0; b < 16; b++) begin
                applyStimulus(1'b0);
                word = {word[14:0], lastSdo};
            end
            if (expQ.size() == 0) begin
                checkOutput("read scoreboard empty", 32'd1, 32'd0);
            end else begin
                checkOutput("read word", {16'd0, word}, {16'd0, expQ.pop_front()});
            end
        end
        endOp();
    endtask

    task automatic writeWord(input logic [5:0] a, input logic [15:0] d);
        lastLow = 0;
        beginOp();
        sendCmd(2'b01, a);
        for (int i = 15; i >= 0; i--) applyStimulus(d[i]);
        if (modelFlag) model[a] = d;
        waitReady("write busy", modelFlag ? 1 : 0);
        endOp();
    endtask

    task automatic special(input string tag, input logic [5:0] a, input int expLow);
        lastLow = 0;
        beginOp();
        sendCmd(2'b00, a);
        waitReady(tag, expLow);
        endOp();
    endtask

    initial begin
        foreach (model[i]) model[i] = 16'hFFFF;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset sdo", {31'd0, sdo}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fresh memory reads as erased
        readWords(6'h32, 1);

        // Single write, then neighbouring word untouched
        writeWord(6'h32, 16'h1234);
        readWords(6'h32, 1);
        readWords(6'h31, 1);

        // Write protection and re-enable
        special("ewds", 6'b000000, 0);
        modelFlag = 1'b0;
        writeWord(6'h32, 16'h0000);
        readWords(6'h32, 1);
        special("ewen", 6'b110000, 0);
        modelFlag = 1'b1;
        writeWord(6'h32, 16'h0000);
        readWords(6'h32, 1);

        // Sequential read wrapping from the top address to zero
        writeWord(6'h3F, 16'hA5A5);
        writeWord(6'h00, 16'h5A5A);
        readWords(6'h3F, 2);

        // Single-word erase
        lastLow = 0;
        beginOp();
        sendCmd(2'b11, 6'h3F);
        model[6'h3F] = 16'hFFFF;
        waitReady("erase busy", 1);
        endOp();
        readWords(6'h3F, 1);

        // Erase all, then write all
        special("eral", 6'b100000, 64);
        foreach (model[i]) model[i] = 16'hFFFF;
        readWords(6'h00, 64);
        lastLow = 0;
        beginOp();
        sendCmd(2'b00, 6'b010000);
        for (int i = 15; i >= 0; i--) applyStimulus(logic'(16'hBEEF >> i));
        foreach (model[i]) model[i] = 16'hBEEF;
        waitReady("wral busy", 64);
        endOp();
        readWords(6'h00, 64);

        // Abort after half the data bits
        beginOp();
        sendCmd(2'b01, 6'h10);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0);
        endOp();
        checkOutput("abort half sdo", {31'd0, sdo}, 32'd1);
        readWords(6'h10, 1);

        // scs falls on the same clk as the last data bit
        lastLow = 0;
        beginOp();
        sendCmd(2'b01, 6'h11);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0);
        @(negedge clk);
        sdi = 1'b0;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        scs  = 1'b0;
        repeat (3) @(negedge clk);
        sclk = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abort last busy", lastLow, 0);
        checkOutput("abort last sdo", {31'd0, sdo}, 32'd1);
        readWords(6'h11, 1);

        // Reset in the middle of a read stream
        beginOp();
        sendCmd(2'b10, 6'h05);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("mid-read reset sdo", {31'd0, sdo}, 32'd1);
        scs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        readWords(6'h05, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
